result_store: RTL and testbench

- Writer end of the result-memory interface that the display block reads.
- Accepts a stream of 8-bit results from the compute stage (PE, 3x3 systolic array or 2x2 systolic array) over a valid/ready handshake.
- Writes the results sequentially into a 12-entry result memory and exposes an asynchronous read port (addr in, data out) for the display stage.
- Active during top-level state S_STORE; signals completion and which compute source filled the memory.

---
 rtl/result_pkg.sv | 47 ++++
 rtl/result_mem.sv | 53 +++++
 rtl/result_store.sv | 119 +++++++++++
 tb/tb_result_store.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// result_pkg: layout shared by the result writer and the display reader.
//   - word width, memory depth and address width
//   - result source (mode) encoding
//   - writer FSM state encoding
//   - number of results produced by each compute source
package result_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = 4;

    localparam int N_PE  = 4;
    localparam int N_SA2 = 4;
    localparam int N_SA3 = 9;

    localparam logic [1:0] MODE_PE  = 2'd0;
    localparam logic [1:0] MODE_SA3 = 2'd1;
    localparam logic [1:0] MODE_SA2 = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Number of words a given source delivers into the memory.
    function automatic logic [ADDR_W-1:0] target_count(input logic [1:0] mode);
        case (mode)
            MODE_SA3: return ADDR_W'(N_SA3);
            MODE_SA2: return ADDR_W'(N_SA2);
            default:  return ADDR_W'(N_PE);
        endcase
    endfunction

    // Completion flag vector, ordered {PE, SA_3x3, SA_2x2}.
    function automatic logic [2:0] mode_flag(input logic [1:0] mode);
        case (mode)
            MODE_PE:  return 3'b100;
            MODE_SA3: return 3'b010;
            MODE_SA2: return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/result_mem.sv
// result_mem: DEPTH x DATA_W register file.
//   clk, reset     : clock, asynchronous active-low clear of every word
//   we, waddr,     : synchronous write port
//   wdata
//   raddr, rdata   : combinational read port; addresses >= DEPTH read 0
// A read of the word being written in the same cycle returns the old value.
module result_mem
    import result_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  we_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign we_vec[gi] = we && (waddr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    // Out-of-range addresses fall through with the zero default.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) begin
                rdata = mem_reg[i];
            end
        end
    end

endmodule

// File: rtl/result_store.sv
// result_store: writer side of the result memory read by the display block.
//   clk, reset        : clock, asynchronous active-low reset
//   run_store         : high while the top level sits in its store state
//   mode_i            : result source 0=PE, 1=SA_3x3, 2=SA_2x2, 3=reserved
//   in_valid, in_data : incoming result words
//   in_ready          : a word is accepted this cycle when in_valid is high
//   addr_result_i     : display read address
//   result_o          : memory[addr_result_i], combinational (0 past the end)
//   done_store_o      : one-cycle pulse after the last expected word is stored
//   PE_result, SA_3x3_result, SA_2x2_result : which source filled the memory
module result_store
    import result_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run_store,
    input  logic [1:0]        mode_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr_result_i,
    output logic [DATA_W-1:0] result_o,
    output logic              done_store_o,
    output logic              PE_result,
    output logic              SA_3x3_result,
    output logic              SA_2x2_result
);

    state_t            state_reg,  state_next;
    logic [ADDR_W-1:0] ptr_reg,    ptr_next;
    logic [ADDR_W-1:0] target_reg, target_next;
    logic [1:0]        mode_reg,   mode_next;
    logic [2:0]        flags_reg,  flags_next;
    logic              in_ready_reg;
    logic              accept;

    assign accept = in_valid && in_ready_reg;

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        target_next = target_reg;
        mode_next   = mode_reg;
        flags_next  = flags_reg;
        case (state_reg)
            IDLE: begin
                if (run_store && (mode_i != MODE_RSV)) begin
                    mode_next   = mode_i;
                    target_next = target_count(mode_i);
                    ptr_next    = '0;
                    flags_next  = '0;
                    state_next  = WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
                // Abort wins over completion: a dropped run_store never
                // produces a done pulse or a flag.
                if (!run_store) begin
                    state_next = IDLE;
                end else if (accept && (ptr_reg == target_reg - ADDR_W'(1))) begin
                    state_next = DONE;
                    flags_next = mode_flag(mode_reg);
                end
            end
            DONE: begin
                state_next = WAIT;
            end
            WAIT: begin
                // Hold here until run_store drops so one store phase
                // cannot fill the memory twice.
                if (!run_store) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            target_reg   <= '0;
            mode_reg     <= MODE_PE;
            flags_reg    <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            target_reg   <= target_next;
            mode_reg     <= mode_next;
            flags_reg    <= flags_next;
            // Registered copy of "state is WRITE", taken from the next state.
            in_ready_reg <= (state_next == WRITE);
        end
    end

    result_mem u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (ptr_reg),
        .wdata (in_data),
        .raddr (addr_result_i),
        .rdata (result_o)
    );

    assign in_ready      = in_ready_reg;
    assign done_store_o  = (state_reg == DONE);
    assign PE_result     = flags_reg[2];
    assign SA_3x3_result = flags_reg[1];
    assign SA_2x2_result = flags_reg[0];

endmodule

// File: tb/tb_result_store.sv
module tb_result_store;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_store;
    logic [1:0] mode_i;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] addr_result_i;
    logic [7:0] result_o;
    logic       done_store_o;
    logic       PE_result;
    logic       SA_3x3_result;
    logic       SA_2x2_result;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: memory image, flags {PE,SA3,SA2}, progress of a run.
    logic [7:0] model_mem [12];
    logic [2:0] model_flags;
    int         model_n;
    int         model_cnt;
    bit         model_active;
    logic [1:0] model_mode;
    logic [7:0] rd_buf [12];

    result_store dut (
        .clk           (clk),
        .reset         (reset),
        .run_store     (run_store),
        .mode_i        (mode_i),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .addr_result_i (addr_result_i),
        .result_o      (result_o),
        .done_store_o  (done_store_o),
        .PE_result     (PE_result),
        .SA_3x3_result (SA_3x3_result),
        .SA_2x2_result (SA_2x2_result)
    );

    always #5 clk = ~clk;

    function automatic int words_for(input logic [1:0] m);
        return (m == 2'd1) ? 9 : 4;
    endfunction

    function automatic logic [2:0] flag_for(input logic [1:0] m);
        return (m == 2'd0) ? 3'b100 : (m == 2'd1) ? 3'b010 : 3'b001;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 12; i++) model_mem[i] = 8'h00;
        model_flags  = 3'b000;
        model_active = 0;
        model_cnt    = 0;
        model_n      = 0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 12; i++) begin
            addr_result_i = 4'(i);
            #1;
            rd_buf[i] = result_o;
        end
    endtask

    task automatic start_run(input logic [1:0] m);
        in_valid  = 0;
        mode_i    = m;
        run_store = 1;
        cycle();
        model_mode   = m;
        model_n      = words_for(m);
        model_cnt    = 0;
        model_flags  = 3'b000;
        model_active = 1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_ready mode=%0d got=%b want=1", m, in_ready);
        end
    endtask

    task automatic stop_run();
        in_valid  = 0;
        run_store = 0;
        cycle();
        model_active = 0;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stop_ready got=%b want=0", in_ready);
        end
    endtask

    // Present n_present valid words (gap_mode 0=back-to-back, 1=every other
    // cycle, 2=random) and follow the model cycle by cycle.
    task automatic push_words(input int n_present, input int gap_mode,
                              input bit fixed_seq, input logic [7:0] base,
                              output int done_seen);
        int presented = 0;
        int cyc = 0;
        logic v;
        logic [7:0] d;
        logic exp_ready;
        logic exp_done;
        done_seen = 0;
        while (presented < n_present && cyc < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = fixed_seq ? 8'(base + 8'(presented)) : 8'($urandom);
            in_valid = v;
            in_data  = d;
            exp_ready = model_active && (model_cnt < model_n);
            n_vec++;
            if (in_ready !== exp_ready) begin
                n_err++;
                $display("FAIL push_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ready);
            end
            cycle();
            exp_done = 1'b0;
            if (v && exp_ready) begin
                model_mem[model_cnt] = d;
                model_cnt++;
                if (model_cnt == model_n) begin
                    exp_done     = 1'b1;
                    model_flags  = flag_for(model_mode);
                    model_active = 0;
                end
            end
            n_vec++;
            if (done_store_o !== exp_done) begin
                n_err++;
                $display("FAIL push_done cyc=%0d got=%b want=%b", cyc, done_store_o, exp_done);
            end
            if (done_store_o === 1'b1) done_seen++;
            if (v) presented++;
            cyc++;
        end
        in_valid = 0;
        n_vec++;
        if (presented < n_present) begin
            n_err++;
            $display("FAIL push_timeout got=%0d want=%0d", presented, n_present);
        end
    endtask

    task automatic test_reset();
        reset = 0; run_store = 0; mode_i = 0; in_valid = 0; in_data = 0; addr_result_i = 0;
        model_reset();
        #1;
        n_vec++;
        if ({in_ready, done_store_o, PE_result, SA_3x3_result, SA_2x2_result} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {in_ready, done_store_o, PE_result, SA_3x3_result, SA_2x2_result});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        read_all();
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (rd_buf[i] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_mem addr=%0d got=%h want=00", i, rd_buf[i]);
            end
        end
        $display("txn reset done");
    endtask

    task automatic check_image(input string tag);
        read_all();
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (rd_buf[i] !== model_mem[i]) begin
                n_err++;
                $display("FAIL %s_mem addr=%0d got=%h want=%h", tag, i, rd_buf[i], model_mem[i]);
            end
        end
        n_vec++;
        if ({PE_result, SA_3x3_result, SA_2x2_result} !== model_flags) begin
            n_err++;
            $display("FAIL %s_flags got=%b want=%b", tag,
                     {PE_result, SA_3x3_result, SA_2x2_result}, model_flags);
        end
    endtask

    task automatic test_sa3_stream();
        int ds;
        start_run(2'd1);
        push_words(9, 0, 1, 8'd1, ds);
        cycle();
        n_vec++;
        if (done_store_o !== 1'b0 || ds != 1) begin
            n_err++;
            $display("FAIL sa3_done_pulses got=%0d want=1 (done now=%b)", ds, done_store_o);
        end
        stop_run();
        check_image("sa3");
        $display("txn sa3_stream words=9 done_pulses=%0d", ds);
    endtask

    task automatic test_pe_gaps();
        int ds;
        start_run(2'd0);
        push_words(4, 1, 1, 8'hA0, ds);
        n_vec++;
        if (ds != 1) begin
            n_err++;
            $display("FAIL pe_done_pulses got=%0d want=1", ds);
        end
        stop_run();
        check_image("pe");
        $display("txn pe_gaps words=4 done_pulses=%0d", ds);
    endtask

    task automatic test_excess();
        int ds;
        start_run(2'd2);
        push_words(6, 0, 0, 8'h00, ds);
        n_vec++;
        if (in_ready !== 1'b0 || ds != 1) begin
            n_err++;
            $display("FAIL excess_state ready=%b want=0 pulses=%0d want=1", in_ready, ds);
        end
        stop_run();
        check_image("excess");
        $display("txn excess presented=6 stored=4");
    endtask

    task automatic test_abort();
        int ds;
        start_run(2'd1);
        push_words(3, 0, 0, 8'h00, ds);
        stop_run();
        n_vec++;
        if ({done_store_o, PE_result, SA_3x3_result, SA_2x2_result} !== 4'b0 || ds != 0) begin
            n_err++;
            $display("FAIL abort_outputs got=%b pulses=%0d want=0000 pulses=0",
                     {done_store_o, PE_result, SA_3x3_result, SA_2x2_result}, ds);
        end
        check_image("abort");
        start_run(2'd2);
        push_words(4, 2, 0, 8'h00, ds);
        n_vec++;
        if (ds != 1) begin
            n_err++;
            $display("FAIL restart_done_pulses got=%0d want=1", ds);
        end
        stop_run();
        check_image("restart");
        $display("txn abort_then_sa2 done_pulses=%0d", ds);
    endtask

    task automatic test_reset_mid_write();
        int ds;
        start_run(2'd1);
        push_words(5, 0, 0, 8'h00, ds);
        #2;
        reset = 0;
        #1;
        n_vec++;
        if ({in_ready, done_store_o, PE_result, SA_3x3_result, SA_2x2_result} !== 5'b0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%b want=00000",
                     {in_ready, done_store_o, PE_result, SA_3x3_result, SA_2x2_result});
        end
        model_reset();
        run_store = 0;
        check_image("midreset");
        @(negedge clk);
        reset = 1;
        $display("txn reset_mid_write after 5 words");
    endtask

    task automatic test_read_edges();
        int ds;
        logic [7:0] d;
        for (int a = 12; a < 16; a++) begin
            addr_result_i = 4'(a);
            #1;
            n_vec++;
            if (result_o !== 8'h00) begin
                n_err++;
                $display("FAIL oob_read addr=%0d got=%h want=00", a, result_o);
            end
        end
        start_run(2'd0);
        push_words(2, 0, 0, 8'h00, ds);
        d = ~model_mem[2];
        addr_result_i = 4'd2;
        in_valid = 1;
        in_data  = d;
        #1;
        n_vec++;
        if (result_o !== model_mem[2]) begin
            n_err++;
            $display("FAIL rw_same_old got=%h want=%h", result_o, model_mem[2]);
        end
        cycle();
        model_mem[2] = d;
        model_cnt++;
        in_valid = 0;
        n_vec++;
        if (result_o !== d) begin
            n_err++;
            $display("FAIL rw_same_new got=%h want=%h", result_o, d);
        end
        push_words(1, 0, 0, 8'h00, ds);
        n_vec++;
        if (ds != 1) begin
            n_err++;
            $display("FAIL rw_done_pulses got=%0d want=1", ds);
        end
        stop_run();
        check_image("rw");
        // Reserved mode never starts a run and leaves the flags alone.
        mode_i = 2'd3;
        run_store = 1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_vec++;
            if (in_ready !== 1'b0 || done_store_o !== 1'b0) begin
                n_err++;
                $display("FAIL reserved_mode ready=%b done=%b want=0 0", in_ready, done_store_o);
            end
        end
        run_store = 0;
        cycle();
        check_image("reserved");
        $display("txn read_edges oob/rw_same/reserved");
    endtask

    task automatic test_random_runs();
        int ds;
        logic [1:0] m;
        for (int r = 0; r < 6; r++) begin
            m = 2'($urandom_range(0, 2));
            start_run(m);
            push_words(words_for(m) + int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 8'h00, ds);
            n_vec++;
            if (ds != 1) begin
                n_err++;
                $display("FAIL rand_done_pulses run=%0d got=%0d want=1", r, ds);
            end
            stop_run();
            check_image("rand");
            $display("txn random run=%0d mode=%0d", r, m);
        end
    endtask

    initial begin
        test_reset();
        test_sa3_stream();
        test_pe_gaps();
        test_excess();
        test_abort();
        test_reset_mid_write();
        test_read_edges();
        test_random_runs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
